// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution stage: mode encodings, the
// box-average reciprocal, Sobel kernel weights and default widths.
package conv_pkg;

  localparam int DEF_PIXEL_W = 8;
  localparam int DEF_COEF_W  = 8;
  localparam int NUM_TAPS    = 9;

  // Runtime filter select; the reserved code behaves like a box average.
  typedef enum logic [1:0] {
    MODE_BOX    = 2'd0,
    MODE_KERNEL = 2'd1,
    MODE_SOBEL  = 2'd2,
    MODE_RSVD   = 2'd3
  } conv_mode_e;

  // Divide-by-9 approximation: (sum * 57) >> 9. 57/512 is slightly above 1/9,
  // so a uniform window of value v (v < 512) returns exactly v.
  localparam int BOX_RECIP = 57;
  localparam int BOX_SHIFT = 9;

  // Sobel weights, tap k = row-major position in the window (k=0 top-left).
  localparam logic signed [2:0] SOBEL_GX [NUM_TAPS] = '{
    -3'sd1,  3'sd0,  3'sd1,
    -3'sd2,  3'sd0,  3'sd2,
    -3'sd1,  3'sd0,  3'sd1
  };
  localparam logic signed [2:0] SOBEL_GY [NUM_TAPS] = '{
    -3'sd1, -3'sd2, -3'sd1,
     3'sd0,  3'sd0,  3'sd0,
     3'sd1,  3'sd2,  3'sd1
  };

endpackage

// File: rtl/conv3x3_sat.sv
// Arithmetic right shift followed by clamping of a signed value into the
// unsigned pixel range [0, 2^PIXEL_W-1]. Shared by all filter modes.
module conv3x3_sat
  import conv_pkg::*;
#(
  parameter int IN_W    = 27,
  parameter int PIXEL_W = DEF_PIXEL_W
) (
  input  logic signed [IN_W-1:0]  value,
  input  logic [3:0]              shift,
  output logic [PIXEL_W-1:0]      pixel
);

  localparam logic signed [IN_W-1:0] PIX_MAX = {{(IN_W-PIXEL_W){1'b0}}, {PIXEL_W{1'b1}}};

  logic signed [IN_W-1:0] shifted;

  // Shift, then clamp negatives to zero and large values to full scale
  always_comb begin
    shifted = value >>> shift;
    if (shifted[IN_W-1]) begin
      pixel = '0;
    end else if (shifted > PIX_MAX) begin
      pixel = '1;
    end else begin
      pixel = shifted[PIXEL_W-1:0];
    end
  end

endmodule

// File: rtl/conv3x3_pipe.sv
// Three-stage 3x3 convolution: box average, programmable signed kernel or
// Sobel |Gx|+|Gy|, one result per valid window, fixed three-register latency.
// Optional build macro CONV3X3_THRESH_EN adds i_thresh and turns the output
// into a binary edge map (all-ones when filtered value >= i_thresh).
module conv3x3_pipe
  import conv_pkg::*;
#(
  parameter int PIXEL_W = DEF_PIXEL_W,
  parameter int COEF_W  = DEF_COEF_W,
  parameter int ACC_W   = PIXEL_W + COEF_W + 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [9*PIXEL_W-1:0]   i_pixel_data,
  input  logic                   i_pixel_data_valid,
  input  logic [1:0]             i_mode,
  input  logic [3:0]             i_shift,
  input  logic                   i_coef_we,
  input  logic [3:0]             i_coef_addr,
  input  logic [COEF_W-1:0]      i_coef_data,
`ifdef CONV3X3_THRESH_EN
  input  logic [PIXEL_W-1:0]     i_thresh,
`endif
  output logic [PIXEL_W-1:0]     o_convolved_data,
  output logic                   o_convolved_data_valid
);

  // Unsigned pixel (zero-extended by one bit) times signed coefficient.
  localparam int PROD_W = PIXEL_W + COEF_W + 1;
  // Stage-3 operand must hold sum * 57 for the box path.
  localparam int SAT_W  = ACC_W + 7;

  // ---------------------------------------------------------------------
  // Coefficient bank
  // ---------------------------------------------------------------------
  logic signed [COEF_W-1:0] coef [NUM_TAPS];

  // Address-decoded coefficient writes; addresses past the last tap fall through
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef[k] <= COEF_W'(1);
      end
    end else if (i_coef_we) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (i_coef_addr == 4'(k)) begin
          coef[k] <= i_coef_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: per-tap terms and Sobel gradients
  // ---------------------------------------------------------------------
  logic [PIXEL_W-1:0]        pix     [NUM_TAPS];
  logic signed [ACC_W-1:0]   pix_ext [NUM_TAPS];
  logic signed [PROD_W-1:0]  term_c  [NUM_TAPS];
  logic signed [ACC_W-1:0]   gx_c;
  logic signed [ACC_W-1:0]   gy_c;
  conv_mode_e                mode_c;

  logic                      s1_valid;
  conv_mode_e                s1_mode;
  logic [3:0]                s1_shift;
  logic signed [PROD_W-1:0]  s1_term [NUM_TAPS];
  logic signed [ACC_W-1:0]   s1_gx;
  logic signed [ACC_W-1:0]   s1_gy;

  // Unpack the window and widen each pixel as a non-negative signed value
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      pix[k]     = i_pixel_data[k*PIXEL_W +: PIXEL_W];
      pix_ext[k] = $signed(ACC_W'(pix[k]));
    end
  end

  // Select per-tap term by mode: kernel uses products, box/Sobel use raw pixels
  always_comb begin
    mode_c = conv_mode_e'(i_mode);
    if (mode_c == MODE_RSVD) begin
      mode_c = MODE_BOX;
    end
    gx_c = '0;
    gy_c = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (mode_c == MODE_KERNEL) begin
        term_c[k] = PROD_W'($signed({1'b0, pix[k]})) * PROD_W'(coef[k]);
      end else begin
        term_c[k] = PROD_W'($signed({1'b0, pix[k]}));
      end
      gx_c = gx_c + pix_ext[k] * ACC_W'(SOBEL_GX[k]);
      gy_c = gy_c + pix_ext[k] * ACC_W'(SOBEL_GY[k]);
    end
  end

  // Capture stage-1 data; mode and shift travel with the window they belong to
  always_ff @(posedge i_clk) begin
    s1_mode  <= mode_c;
    s1_shift <= i_shift;
    s1_term  <= term_c;
    s1_gx    <= gx_c;
    s1_gy    <= gy_c;
  end

  // ---------------------------------------------------------------------
  // Stage 2: accumulate
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0]   sum_c;

  logic                      s2_valid;
  conv_mode_e                s2_mode;
  logic [3:0]                s2_shift;
  logic signed [ACC_W-1:0]   s2_sum;
  logic signed [ACC_W-1:0]   s2_gx;
  logic signed [ACC_W-1:0]   s2_gy;

  // Sign-extended adder tree over the nine terms
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      sum_c = sum_c + ACC_W'(s1_term[k]);
    end
  end

  // Capture stage-2 sums alongside the window's mode and shift
  always_ff @(posedge i_clk) begin
    s2_mode  <= s1_mode;
    s2_shift <= s1_shift;
    s2_sum   <= sum_c;
    s2_gx    <= s1_gx;
    s2_gy    <= s1_gy;
  end

  // Valid strobe advances every cycle; reset drops anything in flight
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= i_pixel_data_valid;
      s2_valid <= s1_valid;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: normalise, saturate, optional threshold
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0]   mag_x;
  logic signed [ACC_W-1:0]   mag_y;
  logic signed [SAT_W-1:0]   sat_value;
  logic [3:0]                sat_shift;
  logic [PIXEL_W-1:0]        filt;
  logic [PIXEL_W-1:0]        out_c;

  // Route each mode onto the shared shift/clamp unit
  always_comb begin
    mag_x = s2_gx[ACC_W-1] ? -s2_gx : s2_gx;
    mag_y = s2_gy[ACC_W-1] ? -s2_gy : s2_gy;
    case (s2_mode)
      MODE_KERNEL: begin
        sat_value = SAT_W'(s2_sum);
        sat_shift = s2_shift;
      end
      MODE_SOBEL: begin
        sat_value = SAT_W'(mag_x) + SAT_W'(mag_y);
        sat_shift = 4'd0;
      end
      default: begin
        sat_value = SAT_W'(s2_sum) * SAT_W'(BOX_RECIP);
        sat_shift = 4'(BOX_SHIFT);
      end
    endcase
  end

  conv3x3_sat #(
    .IN_W    (SAT_W),
    .PIXEL_W (PIXEL_W)
  ) u_sat (
    .value (sat_value),
    .shift (sat_shift),
    .pixel (filt)
  );

`ifdef CONV3X3_THRESH_EN
  // Binary edge map: full scale at or above the live threshold, else zero
  always_comb begin
    out_c = (filt >= i_thresh) ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
  end
`else
  // Filtered value goes straight to the output register
  always_comb begin
    out_c = filt;
  end
`endif

  // Output register; data holds its last value while no window is valid
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_convolved_data       <= '0;
      o_convolved_data_valid <= 1'b0;
    end else begin
      o_convolved_data_valid <= s2_valid;
      if (s2_valid) begin
        o_convolved_data <= out_c;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_pipe.sv
// Directed bench for conv3x3_pipe: hand-computed results ride a three-deep
// expected pipeline and are compared with the DUT every cycle.
`timescale 1ns/1ps
module tb_conv3x3_pipe;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic [71:0]   i_pixel_data = '0;
  logic          i_pixel_data_valid = 1'b0;
  logic [1:0]    i_mode = '0;
  logic [3:0]    i_shift = '0;
  logic          i_coef_we = 1'b0;
  logic [3:0]    i_coef_addr = '0;
  logic [7:0]    i_coef_data = '0;
  logic [7:0]    o_convolved_data;
  logic          o_convolved_data_valid;

  int checks = 0;
  int failures = 0;
  int n_drive = 0;
  int obs_valids = 0;

  logic          mon_en = 1'b0;
  logic          cur_v = 1'b0;
  logic [7:0]    cur_d = '0;
  string         cur_tag = "reset";
  logic          ev1 = 1'b0, ev2 = 1'b0, ev3 = 1'b0;
  logic [7:0]    ed1 = '0, ed2 = '0, ed3 = '0;
  string         et1 = "reset", et2 = "reset", et3 = "reset";

  logic [7:0]    kern [9] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h00};

  always #5 i_clk = ~i_clk;

  conv3x3_pipe dut (
    .i_clk                  (i_clk),
    .i_rstn                 (i_rstn),
    .i_pixel_data           (i_pixel_data),
    .i_pixel_data_valid     (i_pixel_data_valid),
    .i_mode                 (i_mode),
    .i_shift                (i_shift),
    .i_coef_we              (i_coef_we),
    .i_coef_addr            (i_coef_addr),
    .i_coef_data            (i_coef_data),
`ifdef CONV3X3_THRESH_EN
    .i_thresh               (8'd0),
`endif
    .o_convolved_data       (o_convolved_data),
    .o_convolved_data_valid (o_convolved_data_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [71:0] uni(input logic [7:0] v);
    return pack9(v, v, v, v, v, v, v, v, v);
  endfunction

  task automatic drive(input string tag, input logic [71:0] px, input logic [1:0] mode,
                       input logic [3:0] sh, input logic [7:0] exp);
    @(negedge i_clk);
    i_coef_we          = 1'b0;
    i_pixel_data       = px;
    i_mode             = mode;
    i_shift            = sh;
    i_pixel_data_valid = 1'b1;
    cur_v   = 1'b1;
    cur_d   = exp;
    cur_tag = tag;
    n_drive++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_coef_we          = 1'b0;
      i_pixel_data_valid = 1'b0;
      i_pixel_data       = 72'({$urandom, $urandom, $urandom});
      cur_v = 1'b0;
    end
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [7:0] d);
    i_coef_we   = 1'b1;
    i_coef_addr = a;
    i_coef_data = d;
  endtask

  // Expected pipeline: three register stages, cleared by reset, data holds
  always @(posedge i_clk) begin
    if (!i_rstn) begin
      ev1 <= 1'b0;
      ev2 <= 1'b0;
      ev3 <= 1'b0;
      ed3 <= '0;
      et3 <= "reset";
    end else begin
      ev1 <= cur_v;
      ed1 <= cur_d;
      et1 <= cur_tag;
      ev2 <= ev1;
      ed2 <= ed1;
      et2 <= et1;
      ev3 <= ev2;
      if (ev2) begin
        ed3 <= ed2;
        et3 <= et2;
      end
    end
  end

  always @(negedge i_clk) begin
    if (mon_en) begin
      check({et3, ".valid"}, 32'(o_convolved_data_valid), 32'(ev3));
      check({et3, ev3 ? ".data" : ".hold"}, 32'(o_convolved_data), 32'(ed3));
      if (o_convolved_data_valid === 1'b1) obs_valids++;
    end
  end

  initial begin
    @(posedge i_clk);
    mon_en = 1'b1;
    idle(1);
    i_rstn = 1'b1;
    idle(2);

    // Box average
    drive("box_max", uni(8'd255), 2'd0, 4'd0, 8'd255);
    idle(5);
    drive("box_nine", uni(8'd9), 2'd0, 4'd0, 8'd9);
    idle(4);
    drive("box_ramp", pack9(0, 1, 2, 3, 4, 5, 6, 7, 8), 2'd0, 4'd0, 8'd4);
    drive("box_corner", pack9(100, 0, 0, 0, 0, 0, 0, 0, 0), 2'd0, 4'd0, 8'd11);
    drive("rsvd_mode", uni(8'd9), 2'd3, 4'd0, 8'd9);
    idle(4);

    // Coefficient write timing against reset-default +1 kernel
    drive("coef_same_edge", uni(8'd1), 2'd1, 4'd0, 8'd9);
    wr_coef(4'd4, 8'd2);
    drive("coef_next", uni(8'd1), 2'd1, 4'd0, 8'd10);
    idle(1);
    wr_coef(4'd12, 8'h32);
    idle(1);
    wr_coef(4'd9, 8'h80);
    idle(1);
    drive("coef_addr_oob", uni(8'd1), 2'd1, 4'd0, 8'd10);
    idle(4);

    // Sharpen kernel
    for (int k = 0; k < 9; k++) begin
      idle(1);
      wr_coef(4'(k), kern[k]);
    end
    idle(1);
    drive("sharp_hi", pack9(10, 10, 10, 10, 100, 10, 10, 10, 10), 2'd1, 4'd0, 8'd255);
    drive("sharp_lo", pack9(100, 100, 100, 100, 10, 100, 100, 100, 100), 2'd1, 4'd0, 8'd0);
    drive("sharp_sh1", pack9(10, 10, 10, 10, 100, 10, 10, 10, 10), 2'd1, 4'd1, 8'd230);
    drive("sharp_sh2", pack9(10, 10, 10, 10, 100, 10, 10, 10, 10), 2'd1, 4'd2, 8'd115);
    drive("sharp_sh15", pack9(10, 10, 10, 10, 100, 10, 10, 10, 10), 2'd1, 4'd15, 8'd0);
    drive("sharp_neg_sh", pack9(100, 100, 100, 100, 10, 100, 100, 100, 100), 2'd1, 4'd1, 8'd0);
    drive("sharp_sh3", pack9(0, 0, 0, 0, 255, 0, 0, 0, 0), 2'd1, 4'd3, 8'd159);
    drive("sharp_flat", uni(8'd50), 2'd1, 4'd0, 8'd50);
    idle(4);

    // Sobel
    drive("sobel_edge", pack9(0, 200, 200, 0, 200, 200, 0, 200, 200), 2'd2, 4'd0, 8'd255);
    drive("sobel_flat", uni(8'd77), 2'd2, 4'd0, 8'd0);
    drive("sobel_x", pack9(0, 20, 20, 0, 20, 20, 0, 20, 20), 2'd2, 4'd0, 8'd80);
    drive("sobel_y", pack9(0, 0, 0, 10, 10, 10, 10, 10, 10), 2'd2, 4'd0, 8'd40);
    drive("sobel_diag", pack9(0, 0, 0, 0, 0, 0, 0, 0, 50), 2'd2, 4'd0, 8'd100);
    drive("sobel_neg", pack9(50, 0, 0, 0, 0, 0, 0, 0, 0), 2'd2, 4'd0, 8'd100);
    idle(4);

    // Back-to-back windows alternating box / Sobel
    for (int i = 0; i < 20; i++) begin
      logic [7:0] v;
      v = 8'(3 * i + 1);
      if (i % 2 == 0)
        drive($sformatf("alt%0d_box", i), uni(v), 2'd0, 4'd0, v);
      else
        drive($sformatf("alt%0d_sobel", i), pack9(0, v, v, 0, v, v, 0, v, v), 2'd2, 4'd0, 8'(4 * v));
    end
    idle(4);

    // Reset with two windows in flight; coefficients return to +1
    drive("dropped_a", uni(8'd3), 2'd1, 4'd0, 8'd3);
    drive("dropped_b", uni(8'd3), 2'd1, 4'd0, 8'd3);
    idle(1);
    i_rstn = 1'b0;
    idle(1);
    i_rstn = 1'b1;
    idle(4);
    drive("after_reset", uni(8'd3), 2'd1, 4'd0, 8'd27);
    idle(5);

    check("valid_count", 32'(obs_valids), 32'(n_drive - 2));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
